// File: rtl/pif_led_sched.sv
// Red/green status LED scheduler: tick prescaler, PWM accumulator and mode FSM arbitrating
// heartbeat against host commands. Define PIF_LED_TMO_EN to revert to heartbeat after TMO_TICKS idle ticks.
module pif_led_sched #(
  parameter int TICK_DIV  = 177333,
  parameter int B         = 5,
  parameter int TMO_TICKS = 1024
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_mode,
  input  logic [1:0]   cmd_color,
  input  logic [B-1:0] cmd_level,
  output logic         busy,
  output logic         tick,
  output logic         red,
  output logic         green,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    ST_HEART   = 2'd0,
    ST_SOLID   = 2'd1,
    ST_BREATHE = 2'd2,
    ST_BLINK   = 2'd3
  } state_t;

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [B-1:0]  LVL_MAX   = '1;

  state_t       r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic         r_ready, r_busy;
  logic [B-1:0] r_level, w_level_nxt;
  logic [1:0]   r_phase, w_phase_nxt;
  logic         r_sub, w_sub_nxt;
  logic [B-1:0] r_bcnt, w_bcnt_nxt;
  logic [1:0]   r_color;
  logic [B-1:0] r_peak;
  logic [B:0]   r_accum;
  logic         r_pwm_on, r_red, r_green;
  logic         w_accept, w_tick, w_tmo_hit;
  logic         w_en_r, w_en_g;
  logic [B-1:0] w_pwm_lvl;

  // Handshake: a command transfers in any cycle where cmd_valid and cmd_ready are both high;
  // cmd_ready then drops for exactly one cycle. A tick landing on the accept cycle is dropped.
  assign w_accept    = cmd_valid & r_ready;
  assign w_tick      = (r_presc == '0) & ~w_accept;
  assign cmd_ready   = r_ready;
  assign busy        = r_busy;
  assign tick        = w_tick;
  assign red         = r_red;
  assign green       = r_green;
  assign o_dbg_state = r_state;

`ifdef PIF_LED_TMO_EN
  localparam int TW = $clog2(TMO_TICKS + 1);
  logic [TW-1:0] r_tmo;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                                  r_tmo <= '0;
    else if (w_accept)                        r_tmo <= '0;
    else if (r_state != ST_HEART && w_tick)   r_tmo <= r_tmo + 1'b1;
  end

  assign w_tmo_hit = (r_state != ST_HEART) && w_tick && (r_tmo == TW'(TMO_TICKS - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TMO_TICKS != 0);
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_HEART;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_phase_nxt = r_phase;
    w_sub_nxt   = r_sub;
    w_bcnt_nxt  = r_bcnt;
    if (w_accept || w_tmo_hit) begin
      w_state_nxt = w_accept ? state_t'(cmd_mode) : ST_HEART;
      w_level_nxt = '0;
      w_phase_nxt = '0;
      w_sub_nxt   = 1'b0;
      w_bcnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_HEART: if (w_tick) begin
          w_level_nxt = r_level + 1'b1;
          if (r_level == LVL_MAX) w_phase_nxt = r_phase + 1'b1;
        end
        ST_SOLID: w_level_nxt = r_peak;
        // r_sub: 0 = ramping up, 1 = ramping down; peak 0 just flips direction each tick
        ST_BREATHE: if (w_tick) begin
          if (!r_sub) begin
            if (r_level == r_peak) begin
              w_sub_nxt = 1'b1;
              if (r_level != '0) w_level_nxt = r_level - 1'b1;
            end else begin
              w_level_nxt = r_level + 1'b1;
            end
          end else begin
            if (r_level == '0) begin
              w_sub_nxt = 1'b0;
              if (r_peak != '0) w_level_nxt = r_level + 1'b1;
            end else begin
              w_level_nxt = r_level - 1'b1;
            end
          end
        end
        ST_BLINK: begin
          w_level_nxt = r_sub ? '0 : r_peak;
          if (w_tick) begin
            w_bcnt_nxt = r_bcnt + 1'b1;
            if (r_bcnt == LVL_MAX) w_sub_nxt = ~r_sub;
          end
        end
        default: ;
      endcase
    end
  end

  // Heartbeat drives one colour per phase pair; odd phases show the inverted (falling) ramp
  always_comb begin
    w_en_r    = r_color[0];
    w_en_g    = r_color[1];
    w_pwm_lvl = r_level;
    if (r_state == ST_HEART) begin
      w_en_r = ~r_phase[1];
      w_en_g = r_phase[1];
      if (r_phase[0]) w_pwm_lvl = ~r_level;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_presc  <= PRESC_MAX;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_level  <= '0;
      r_phase  <= '0;
      r_sub    <= 1'b0;
      r_bcnt   <= '0;
      r_color  <= '0;
      r_peak   <= '0;
      r_accum  <= '0;
      r_pwm_on <= 1'b0;
      r_red    <= 1'b1;
      r_green  <= 1'b1;
    end else begin
      r_ready <= ~w_accept;
      r_busy  <= (w_state_nxt != ST_HEART);
      r_level <= w_level_nxt;
      r_phase <= w_phase_nxt;
      r_sub   <= w_sub_nxt;
      r_bcnt  <= w_bcnt_nxt;
      if (w_accept) begin
        r_color <= cmd_color;
        r_peak  <= cmd_level;
      end
      if (w_accept || r_presc == '0) r_presc <= PRESC_MAX;
      else                           r_presc <= r_presc - 1'b1;
      r_accum  <= {1'b0, r_accum[B-1:0]} + {1'b0, w_pwm_lvl};
      r_pwm_on <= r_accum[B];
      r_red    <= ~(r_pwm_on & w_en_r);
      r_green  <= ~(r_pwm_on & w_en_g);
    end
  end

endmodule
